// File: rtl/reg_dest_pipe_pkg.sv
// reg_dest_pipe_pkg: shared JX2 register-ID constants, latency codes and types
package reg_dest_pipe_pkg;
  typedef logic [5:0] gpr_id_t;
  localparam gpr_id_t JX2_GR_ZZR  = 6'h3F;
  localparam gpr_id_t JX2_GR_IMM  = 6'h3E;
  localparam gpr_id_t JX2_GR_JIMM = 6'h3D;
  localparam logic [1:0] JX2_LAT_EX1 = 2'd1;
  localparam logic [1:0] JX2_LAT_EX2 = 2'd2;
  localparam logic [1:0] JX2_LAT_EX3 = 2'd3;
  function automatic logic is_nosrc(input gpr_id_t id);
    return (id == JX2_GR_ZZR) || (id == JX2_GR_IMM) || (id == JX2_GR_JIMM);
  endfunction
endpackage

// File: rtl/reg_dest_hazchk.sv
// reg_dest_hazchk: per-source interlock compare; youngest matching stage decides
module reg_dest_hazchk
  import reg_dest_pipe_pkg::*;
(
  input  gpr_id_t    src,
  input  gpr_id_t    id1,
  input  logic [1:0] lat1,
  input  gpr_id_t    id2,
  input  logic [1:0] lat2,
  output logic       haz
);
  always_comb haz = is_nosrc(src) ? 1'b0 :
                    (src == id1)  ? (lat1 >= JX2_LAT_EX2) :
                    (src == id2) && (lat2 == JX2_LAT_EX3);
endmodule

// File: rtl/reg_dest_pipe.sv
// reg_dest_pipe: tracks destination IDs/results through EX1-EX3 and raises the ID interlock
module reg_dest_pipe
  import reg_dest_pipe_pkg::*;
#(
  parameter int GPR_ID_W = 6,
  parameter int VAL_W    = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic [GPR_ID_W-1:0] idDstId,
  input  logic [1:0]          idDstLat,
  input  logic [GPR_ID_W-1:0] idSrcRs,
  input  logic [GPR_ID_W-1:0] idSrcRt,
  input  logic [GPR_ID_W-1:0] idSrcRm,
  input  logic [VAL_W-1:0]    exValEx1,
  input  logic [VAL_W-1:0]    exValEx2,
  input  logic [VAL_W-1:0]    exValEx3,
  output logic [GPR_ID_W-1:0] regIdRn1,
  output logic [VAL_W-1:0]    regValRn1,
  output logic [GPR_ID_W-1:0] regIdRn2,
  output logic [VAL_W-1:0]    regValRn2,
  output logic [GPR_ID_W-1:0] regIdRn3,
  output logic [VAL_W-1:0]    regValRn3,
  output logic                stallId
);
  logic [GPR_ID_W-1:0] id1_q, id2_q, id3_q, id1_d, id2_d, id3_d;
  logic [1:0]          lat1_q, lat2_q, lat3_q, lat1_d, lat2_d, lat3_d;
  logic [VAL_W-1:0]    val2_q, val3_q, val2_d, val3_d, rn2_val, rn3_val;
  logic [2:0]          haz;
  logic                stall_raw;
  logic [2:0][GPR_ID_W-1:0] srcs;
  assign srcs = {idSrcRm, idSrcRt, idSrcRs};
  for (genvar i = 0; i < 3; i++) begin : g_haz
    reg_dest_hazchk u_hazchk (
      .src (srcs[i]),
      .id1 (id1_q),
      .lat1(lat1_q),
      .id2 (id2_q),
      .lat2(lat2_q),
      .haz (haz[i])
    );
  end
  always_comb begin
    stall_raw = |haz;
    rn2_val   = (lat2_q == JX2_LAT_EX1) ? val2_q : exValEx2;
    rn3_val   = (lat3_q == JX2_LAT_EX3) ? exValEx3 : val3_q;
    id1_d  = !reset ? JX2_GR_ZZR  : hold ? id1_q  : (stall_raw | flush) ? JX2_GR_ZZR : idDstId;
    lat1_d = !reset ? JX2_LAT_EX1 : hold ? lat1_q : (idDstLat == 2'd0) ? JX2_LAT_EX1 : idDstLat;
    id2_d  = !reset ? JX2_GR_ZZR  : hold ? id2_q  : flush ? JX2_GR_ZZR : id1_q;
    lat2_d = !reset ? JX2_LAT_EX1 : hold ? lat2_q : lat1_q;
    val2_d = !reset ? '0 : hold ? val2_q : (lat1_q == JX2_LAT_EX1) ? exValEx1 : '0;
    // EX2 is already committed, so flush does not touch the EX2->EX3 move
    id3_d  = !reset ? JX2_GR_ZZR  : hold ? id3_q  : id2_q;
    lat3_d = !reset ? JX2_LAT_EX1 : hold ? lat3_q : lat2_q;
    val3_d = !reset ? '0 : hold ? val3_q : (lat2_q <= JX2_LAT_EX2) ? rn2_val : '0;
    regIdRn1  = reset ? id1_q : JX2_GR_ZZR;
    regIdRn2  = reset ? id2_q : JX2_GR_ZZR;
    regIdRn3  = reset ? id3_q : JX2_GR_ZZR;
    regValRn1 = reset ? exValEx1 : '0;
    regValRn2 = reset ? rn2_val : '0;
    regValRn3 = reset ? rn3_val : '0;
    stallId   = reset & stall_raw;
  end
  always_ff @(posedge clock) begin
    id1_q  <= id1_d;
    id2_q  <= id2_d;
    id3_q  <= id3_d;
    lat1_q <= lat1_d;
    lat2_q <= lat2_d;
    lat3_q <= lat3_d;
    val2_q <= val2_d;
    val3_q <= val3_d;
  end
endmodule

// File: doc/reg_dest_pipe.md
Name: reg_dest_pipe

Overview:
- Destination-tracking pipeline between decode (ID) and the GPR file.
- Carries each instruction's destination register ID and result through EX1/EX2/EX3.
- Presents the Rn1/Rn2/Rn3 ID/value pairs that the register file forwards from and retires at EX3.
- Raises an interlock when a decoded source names a destination whose result is not yet produced.

Parameters:
- GPR_ID_W, 6, register ID width (IDs 0x00-0x1F = gprArr, 0x20-0x3F = specials).
- VAL_W, 64, result width.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-low; 0 sampled at posedge resets
- hold  in  1  global pipeline hold; freezes all state
- flush  in  1  kill younger instructions (branch taken / fault)
- idDstId  in  6  destination ID of instruction leaving ID; JX2_GR_ZZR = none
- idDstLat  in  2  result ready at: 1=EX1, 2=EX2, 3=EX3; 0 treated as 1
- idSrcRs / idSrcRt / idSrcRm  in  6 each  source IDs being decoded
- exValEx1  in  64  result computed in EX1 this cycle
- exValEx2  in  64  result computed in EX2 this cycle
- exValEx3  in  64  result computed in EX3 this cycle
- regIdRn1 / regValRn1  out  6 / 64  EX1 destination and value
- regIdRn2 / regValRn2  out  6 / 64  EX2 destination and value
- regIdRn3 / regValRn3  out  6 / 64  EX3 destination and value; register file writes it
- stallId  out  1  interlock; decode must not advance

Behaviour:
- State per stage k in {1,2,3}: id_k, lat_k, val_k.
  - val_1 does not exist; EX1 uses exValEx1 directly.
  - val_2 = value captured from EX1.
  - val_3 = value captured from EX2.
- Reset (reset==0 at posedge): all id_k = JX2_GR_ZZR, lat_k = 1, val_k = 0.
  - While reset is held, every regIdRn* = ZZR and regValRn* = 0.
  - stallId = 0.
- Advance (reset==1, hold==0), per posedge:
  - id_3 <= id_2, lat_3 <= lat_2; val_3 <= (lat_2<=2) ? regValRn2 : 0.
  - id_2 <= id_1, lat_2 <= lat_1; val_2 <= (lat_1==1) ? exValEx1 : 0.
  - id_1 <= (stallId | flush) ? ZZR : idDstId; lat_1 <= idDstLat (0 mapped to 1).
- Flush (flush==1, hold==0): id_1 <= ZZR, id_2 <= ZZR. EX2→EX3 advances normally, because EX2 is already committed.
- hold==1: no state changes, including under flush or stall.
- reset wins over hold and flush.
- Output muxing (combinational):
  - regIdRn1 = id_1; regValRn1 = exValEx1.
  - regIdRn2 = id_2; regValRn2 = (lat_2==1) ? val_2 : exValEx2.
  - regIdRn3 = id_3; regValRn3 = (lat_3==3) ? exValEx3 : val_3.
- Interlock (combinational), for each source S among Rs/Rt/Rm:
  - Ignore S if it is ZZR, IMM or JIMM.
  - Hazard if (S==id_1 && lat_1>=2) or (S==id_2 && lat_2==3).
  - stallId = OR of all hazards.
  - stallId is independent of hold; gated low during reset.
- A source that hits a stage whose value is ready produces no stall; the register file's own forwarding covers it.
- Duplicate IDs in several stages: the youngest stage governs the stall decision. EX1 is checked before EX2.
- ZZR in a stage never matches a hazard.
- Special IDs (DLR/DHR/SP/ELR/...) are tracked identically to GPRs.

Decomposition:
- The shared JX2 defines package supplies:
  - JX2_GR_ZZR, JX2_GR_IMM, JX2_GR_JIMM;
  - latency codes JX2_LAT_EX1/EX2/EX3 (2-bit);
  - a 6-bit register-ID typedef.
- One natural sub-module: reg_dest_hazchk, the combinational per-source hazard compare, instantiated three times (Rs, Rt, Rm).

Test Plan:
- Reset sequence: hold reset=0 for 2 cycles with idDstId=5 → all regIdRn* = ZZR, regValRn* = 0, stallId = 0.
- ALU chain: idDstId=3, lat=1, exValEx1=0x11.
  - Cycle+1: regIdRn1=3, regValRn1=0x11.
  - Cycle+2: regIdRn2=3, regValRn2=0x11.
  - Cycle+3: regIdRn3=3, regValRn3=0x11.
  - stallId never asserts.
- Load-use: issue R4 with lat=3, then decode idSrcRs=4.
  - stallId=1 for 2 cycles and bubbles (ZZR) enter EX1.
  - Third cycle: stallId=0; regValRn3 = exValEx3 = 0xDEAD.
- Lat-2 result: R7 with lat=2, exValEx2=0x77 in EX2 → regValRn2 = 0x77; next cycle regValRn3 = 0x77; a consumer stalls exactly 1 cycle.
- Flush: R8 in EX1, R9 in EX2, R10 issuing, flush=1 → next cycle id_2 = ZZR, id_1 = ZZR, regIdRn3 = 9.
- Hold: hold=1 for 3 cycles mid-stream → all regIdRn*/stored values unchanged; stallId still tracks source changes combinationally.
